// File: rtl/digdug_arb_pkg.sv
// rtl/digdug_arb_pkg.sv - shared types and constants for the DigDug I/O bus arbiter
package digdug_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam int         NREQ      = 3;
  localparam logic [1:0] MAIN      = 2'd0;
  localparam logic [1:0] SUB       = 2'd1;
  localparam logic [1:0] SOUND     = 2'd2;
  localparam logic [7:0] RDATA_RST = 8'hFF;

  // Requester index to its one-hot ACK/GNT position.
  function automatic logic [NREQ-1:0] idx_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // Next requester index, wrapping 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == SOUND) ? MAIN : idx + 2'd1;
  endfunction

endpackage

// File: rtl/digdug_rr_pick3.sv
// rtl/digdug_rr_pick3.sv - combinational winner pick; DIGDUG_ARB_MAIN_PRIO_EN selects main-priority mode
module digdug_rr_pick3
  import digdug_arb_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  input  logic [1:0]      last,
  output logic [1:0]      win,
  output logic            win_vld
);

`ifdef DIGDUG_ARB_MAIN_PRIO_EN
  // Main always wins when eligible; sub and sound alternate based on which went last.
  always_comb begin
    win     = MAIN;
    win_vld = |elig;
    if (elig[MAIN]) begin
      win = MAIN;
    end else if (last == SUB) begin
      win = elig[SOUND] ? SOUND : SUB;
    end else begin
      win = elig[SUB] ? SUB : SOUND;
    end
  end
`else
  logic [1:0] c1, c2, c3;

  // Search order starts one past the previous winner so every requester gets a turn.
  always_comb begin
    c1      = next_idx(last);
    c2      = next_idx(c1);
    c3      = next_idx(c2);
    win     = MAIN;
    win_vld = |elig;
    if (elig[c1]) begin
      win = c1;
    end else if (elig[c2]) begin
      win = c2;
    end else if (elig[c3]) begin
      win = c3;
    end
  end
`endif

endmodule

// File: rtl/digdug_bus_arbiter.sv
// rtl/digdug_bus_arbiter.sv - main/sub/sound CPU arbiter for the DigDug I/O bus (option: DIGDUG_ARB_MAIN_PRIO_EN)
module digdug_bus_arbiter
  import digdug_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clkdiv,
  input  logic        RESET,
  input  logic [2:0]  REQ,
  input  logic [2:0]  REQWR,
  input  logic [47:0] REQAD,
  input  logic [23:0] REQDI,
  input  logic [2:0]  RSTS,
  output logic [2:0]  ACK,
  output logic [7:0]  RDATA,
  output logic [2:0]  GNT,
  output logic [15:0] AD,
  output logic        WR,
  output logic        RD,
  output logic [7:0]  DI,
  input  logic [7:0]  DO,
  input  logic        DV
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  arb_state_t  state, state_nx;
  logic [1:0]  win_q;
  logic [1:0]  last_q;
  logic        wr_q;
  logic [15:0] ad_q;
  logic [7:0]  di_q;
  logic [7:0]  rdata_q;
  logic [2:0]  cnt_q;

  logic [NREQ-1:0] elig;
  logic [1:0]      pick;
  logic            pick_vld;
  logic [15:0]     sel_ad;
  logic [7:0]      sel_di;
  logic            sel_wr;

  // CPUs held in reset by the control latch drop out of arbitration.
  assign elig = REQ & ~RSTS;

  digdug_rr_pick3 u_pick (
    .elig    (elig),
    .last    (last_q),
    .win     (pick),
    .win_vld (pick_vld)
  );

  // Route the winner's request fields toward the capture registers.
  always_comb begin
    sel_ad = REQAD[15:0];
    sel_di = REQDI[7:0];
    sel_wr = REQWR[0];
    case (pick)
      SUB: begin
        sel_ad = REQAD[31:16];
        sel_di = REQDI[15:8];
        sel_wr = REQWR[1];
      end
      SOUND: begin
        sel_ad = REQAD[47:32];
        sel_di = REQDI[23:16];
        sel_wr = REQWR[2];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: one strobe cycle, WAIT_CYCLES of wait, one ACK cycle, then back to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = STROBE;
      STROBE:  state_nx = WAIT;
      WAIT:    if (cnt_q == WAIT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction capture, wait counter, read-data capture and round-robin history.
  always_ff @(posedge clkdiv or posedge RESET) begin
    if (RESET) begin
      win_q   <= MAIN;
      last_q  <= SOUND;
      wr_q    <= 1'b0;
      ad_q    <= 16'h0000;
      di_q    <= 8'h00;
      rdata_q <= RDATA_RST;
      cnt_q   <= 3'd0;
    end else begin
      if (state == IDLE && pick_vld) begin
        win_q <= pick;
        wr_q  <= sel_wr;
        ad_q  <= sel_ad;
        di_q  <= sel_di;
      end
      if (state == STROBE) begin
        cnt_q <= 3'd0;
      end else if (state == WAIT) begin
        cnt_q <= cnt_q + 3'd1;
      end
      // Capture on the edge into DONE so RDATA is already valid alongside ACK.
      if (state == WAIT && state_nx == DONE && !wr_q) begin
        rdata_q <= DV ? DO : RDATA_RST;
      end
      if (state == DONE) begin
`ifdef DIGDUG_ARB_MAIN_PRIO_EN
        if (win_q != MAIN) last_q <= win_q;
`else
        last_q <= win_q;
`endif
      end
    end
  end

  // Bus and handshake outputs decode from state, so a reset clears them immediately.
  always_comb begin
    AD    = ad_q;
    DI    = di_q;
    RDATA = rdata_q;
    WR    = (state == STROBE) && wr_q;
    RD    = ((state == STROBE) || (state == WAIT)) && !wr_q;
    GNT   = (state != IDLE) ? idx_onehot(win_q) : 3'b000;
    ACK   = (state == DONE) ? idx_onehot(win_q) : 3'b000;
  end

endmodule

// File: tb/tb_digdug_bus_arbiter.sv
// tb/tb_digdug_bus_arbiter.sv - directed self-checking bench for digdug_bus_arbiter
module tb_digdug_bus_arbiter;

  logic        clkdiv = 1'b0;
  logic        RESET  = 1'b1;
  logic [2:0]  REQ    = '0;
  logic [2:0]  REQWR  = '0;
  logic [47:0] REQAD  = '0;
  logic [23:0] REQDI  = '0;
  logic [2:0]  RSTS   = '0;
  logic [2:0]  ACK;
  logic [7:0]  RDATA;
  logic [2:0]  GNT;
  logic [15:0] AD;
  logic        WR;
  logic        RD;
  logic [7:0]  DI;
  logic [7:0]  DO = 8'h00;
  logic        DV = 1'b0;
  logic        preload = 1'b1;

  logic [7:0]  mem [0:8191];

  int n_tests = 0;
  int n_fail  = 0;

  digdug_bus_arbiter #(.WAIT_CYCLES(1)) dut (
    .clkdiv (clkdiv),
    .RESET  (RESET),
    .REQ    (REQ),
    .REQWR  (REQWR),
    .REQAD  (REQAD),
    .REQDI  (REQDI),
    .RSTS   (RSTS),
    .ACK    (ACK),
    .RDATA  (RDATA),
    .GNT    (GNT),
    .AD     (AD),
    .WR     (WR),
    .RD     (RD),
    .DI     (DI),
    .DO     (DO),
    .DV     (DV)
  );

  always #5 clkdiv = ~clkdiv;

  // Synchronous RAM at $8000-$9FFF, one-cycle read latency; everything else is unmapped.
  always @(posedge clkdiv) begin
    if (preload) mem[13'h0005] <= 8'h5A;
    if (WR && AD[15:13] == 3'b100) mem[AD[12:0]] <= DI;
    if (RD) begin
      DO <= mem[AD[12:0]];
      DV <= (AD[15:13] == 3'b100);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkdiv);
    #1;
  endtask

  task automatic run_txn(input int idx, input logic wr, input logic [15:0] addr, input logic [7:0] data,
                         output logic [2:0] ack, output logic [7:0] rdata, output int wrs,
                         output logic [15:0] wad, output logic [7:0] wdi);
    REQ   = 3'b001 << idx;
    REQWR = wr ? (3'b001 << idx) : 3'b000;
    REQAD = 48'(addr) << (16 * idx);
    REQDI = 24'(data) << (8 * idx);
    ack = 3'b000; rdata = 8'h00; wrs = 0; wad = 16'h0; wdi = 8'h0;
    for (int i = 0; i < 20 && ack == 3'b000; i++) begin
      tick();
      if (WR) begin
        wrs++;
        wad = AD;
        wdi = DI;
      end
      ack   = ACK;
      rdata = RDATA;
    end
    REQ = 3'b000;
    tick();
  endtask

  task automatic wait_ack(output logic [2:0] ack, output int cyc);
    ack = 3'b000;
    cyc = 0;
    for (int i = 0; i < 20 && ack == 3'b000; i++) begin
      tick();
      cyc++;
      ack = ACK;
    end
  endtask

  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic [15:0] wad;
  logic [7:0]  wdi;
  logic [2:0]  exp_ack;
  int          wrs;
  int          cyc;

  initial begin
    tick();
    tick();
    check("rst_ad", AD, 16'h0000);
    check("rst_di", DI, 8'h00);
    check("rst_wr", WR, 1'b0);
    check("rst_rd", RD, 1'b0);
    check("rst_ack", ACK, 3'b000);
    check("rst_gnt", GNT, 3'b000);
    check("rst_rdata", RDATA, 8'hFF);
    RESET = 1'b0;
    preload = 1'b0;
    tick();

    // Main read of $8005 with exact cycle timing.
    REQ = 3'b001; REQWR = 3'b000; REQAD = 48'h0000_0000_8005;
    tick();
    check("rd_strobe", RD, 1'b1);
    check("gnt_strobe", GNT, 3'b001);
    check("ad_strobe", AD, 16'h8005);
    check("ack_strobe", ACK, 3'b000);
    tick();
    check("rd_wait", RD, 1'b1);
    check("ack_wait", ACK, 3'b000);
    tick();
    check("ack_main", ACK, 3'b001);
    check("rdata_5a", RDATA, 8'h5A);
    REQ = 3'b000;
    tick();
    check("gnt_idle", GNT, 3'b000);
    check("ack_idle", ACK, 3'b000);

    // Sub write of $3C to $9B80, then read it back through main.
    run_txn(1, 1'b1, 16'h9B80, 8'h3C, ack, rdata, wrs, wad, wdi);
    check("wr_ack_sub", ack, 3'b010);
    check("wr_pulses", wrs, 1);
    check("wr_ad", wad, 16'h9B80);
    check("wr_di", wdi, 8'h3C);
    run_txn(0, 1'b0, 16'h9B80, 8'h00, ack, rdata, wrs, wad, wdi);
    check("rb_ack", ack, 3'b001);
    check("rb_rdata", rdata, 8'h3C);
    check("rb_no_wr", wrs, 0);

    // Unmapped read returns $FF.
    run_txn(2, 1'b0, 16'h5000, 8'h00, ack, rdata, wrs, wad, wdi);
    check("unm_ack", ack, 3'b100);
    check("unm_rdata", rdata, 8'hFF);

    // All three requesting continuously from reset.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    REQ = 3'b111; REQWR = 3'b000; REQAD = 48'h8001_8002_8003;
    for (int k = 0; k < 9; k++) begin
      wait_ack(ack, cyc);
`ifdef DIGDUG_ARB_MAIN_PRIO_EN
      exp_ack = 3'b001;
`else
      exp_ack = 3'b001 << (k % 3);
`endif
      check($sformatf("rr_order%0d", k), ack, exp_ack);
      if (k > 0) check($sformatf("rr_spacing%0d", k), cyc, 4);
    end
    REQ = 3'b000;
    tick();
    tick();

    // Sub and sound held in reset: only main is served.
    RSTS = 3'b110; REQ = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(ack, cyc);
      check($sformatf("rsts_ack%0d", k), ack, 3'b001);
    end
    REQ = 3'b000;
    tick();
    tick();
    RSTS = 3'b000;

    // Reset during WAIT of a sub read.
    REQ = 3'b010; REQWR = 3'b000; REQAD = 48'h0000_8005_0000;
    tick();
    check("mid_gnt_strobe", GNT, 3'b010);
    tick();
    check("mid_rd_wait", RD, 1'b1);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_gnt", GNT, 3'b000);
    check("mid_rst_rd", RD, 1'b0);
    check("mid_rst_wr", WR, 1'b0);
    check("mid_rst_ack", ACK, 3'b000);
    check("mid_rst_ad", AD, 16'h0000);
    check("mid_rst_rdata", RDATA, 8'hFF);
    REQ = 3'b011; REQAD = 48'h0000_8005_8005;
    tick();
    check("mid_rst_ack_hold", ACK, 3'b000);
    RESET = 1'b0;
    wait_ack(ack, cyc);
    check("post_rst_main", ack, 3'b001);
    REQ = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
